// File: rtl/tea_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tea_pkg : shared FSM encoding, frame lengths and operand slot indices
//           for the TEA stream controller.
// Revision: 1.0
// ---------------------------------------------------------------------------
package tea_pkg;

  localparam int c_word_size_def   = 16;
  localparam int c_frame_len_full  = 6;
  localparam int c_frame_len_short = 2;

  localparam logic [2:0] c_idx_k0 = 3'd0;
  localparam logic [2:0] c_idx_k1 = 3'd1;
  localparam logic [2:0] c_idx_k2 = 3'd2;
  localparam logic [2:0] c_idx_k3 = 3'd3;
  localparam logic [2:0] c_idx_v0 = 3'd4;
  localparam logic [2:0] c_idx_v1 = 3'd5;

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/tea_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tea_watchdog : loadable WAIT-cycle counter; expired marks the
//                TIMEOUT-th counted cycle.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tea_watchdog #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = $clog2(TIMEOUT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] count,
  output logic             expired
);

  localparam logic [CNT_W-1:0] c_last = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en && (r_count != c_last)) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count   = r_count;
  assign expired = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/tea_stream_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tea_stream_ctrl : valid/ready front-end for the TEA core (load, start,
//                   wait with watchdog, result out). Option: TEA_KEY_RETAIN_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tea_stream_ctrl
  import tea_pkg::*;
#(
  parameter int WORD_SIZE = c_word_size_def,
  parameter int TIMEOUT   = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_SIZE-1:0]   iData,
  input  logic                   iValid,
`ifdef TEA_KEY_RETAIN_EN
  input  logic                   iNewKey,
`endif
  output logic                   oReady,
  output logic [WORD_SIZE-1:0]   oV0,
  output logic [WORD_SIZE-1:0]   oV1,
  output logic [WORD_SIZE-1:0]   oK0,
  output logic [WORD_SIZE-1:0]   oK1,
  output logic [WORD_SIZE-1:0]   oK2,
  output logic [WORD_SIZE-1:0]   oK3,
  output logic                   oStart,
  input  logic [WORD_SIZE-1:0]   iC0,
  input  logic [WORD_SIZE-1:0]   iC1,
  input  logic                   iDone,
  output logic [2*WORD_SIZE-1:0] oResult,
  output logic                   oValid,
  input  logic                   iReady,
  output logic                   oBusy,
  output logic                   oTimeout
);

  localparam int c_cnt_w = $clog2(TIMEOUT + 1);

  state_t                 r_state;
  state_t                 w_next;
  logic [2:0]             r_cnt;
  logic [2:0]             w_idx;
  logic                   w_accept;
  logic                   w_short;
  logic                   w_last;
  logic                   w_done_ok;
  logic [c_cnt_w-1:0]     w_wd_count;
  logic                   w_wd_expired;
  logic [WORD_SIZE-1:0]   r_v0, r_v1, r_k0, r_k1, r_k2, r_k3;
  logic [2*WORD_SIZE-1:0] r_result;

  assign w_accept = iValid && (r_state == ST_LOAD);

`ifdef TEA_KEY_RETAIN_EN
  // Frame kind is decided by the first word and remembered for the rest.
  logic r_short;
  assign w_short = (r_cnt == 3'd0) ? ~iNewKey : r_short;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_short <= 1'b0;
    end else if (w_accept && (r_cnt == 3'd0)) begin
      r_short <= ~iNewKey;
    end
  end
`else
  assign w_short = 1'b0;
`endif

  // Short frames skip the key slots and land directly on V0/V1.
  assign w_idx  = w_short ? (r_cnt + 3'(c_frame_len_full - c_frame_len_short)) : r_cnt;
  assign w_last = (w_idx == c_idx_v1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= 3'd0;
    end else if (w_accept) begin
      r_cnt <= w_last ? 3'd0 : (r_cnt + 3'd1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_k0 <= '0;
      r_k1 <= '0;
      r_k2 <= '0;
      r_k3 <= '0;
      r_v0 <= '0;
      r_v1 <= '0;
    end else if (w_accept) begin
      case (w_idx)
        c_idx_k0: r_k0 <= iData;
        c_idx_k1: r_k1 <= iData;
        c_idx_k2: r_k2 <= iData;
        c_idx_k3: r_k3 <= iData;
        c_idx_v0: r_v0 <= iData;
        c_idx_v1: r_v1 <= iData;
        default:  r_v1 <= r_v1;
      endcase
    end
  end

  tea_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (c_cnt_w)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clear    (r_state != ST_WAIT),
    .en       (r_state == ST_WAIT),
    .load     (1'b0),
    .load_val ('0),
    .count    (w_wd_count),
    .expired  (w_wd_expired)
  );

  // A done seen in the first WAIT cycle may predate the core's reset.
  assign w_done_ok = iDone && (w_wd_count != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_result <= '0;
    end else if ((r_state == ST_WAIT) && w_done_ok) begin
      r_result <= {iC0, iC1};
    end else if ((r_state == ST_OUT) && iReady) begin
      r_result <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    oReady   = 1'b0;
    oStart   = 1'b0;
    oValid   = 1'b0;
    oBusy    = 1'b1;
    oTimeout = 1'b0;
    case (r_state)
      ST_LOAD: begin
        oBusy  = 1'b0;
        oReady = 1'b1;
        if (w_accept && w_last) w_next = ST_START;
      end
      ST_START: begin
        oStart = 1'b1;
        w_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (w_done_ok) begin
          w_next = ST_OUT;
        end else if (w_wd_expired) begin
          oTimeout = 1'b1;
          w_next   = ST_LOAD;
        end
      end
      ST_OUT: begin
        oValid = 1'b1;
        if (iReady) w_next = ST_LOAD;
      end
      default: w_next = ST_LOAD;
    endcase
  end

  assign oV0     = r_v0;
  assign oV1     = r_v1;
  assign oK0     = r_k0;
  assign oK1     = r_k1;
  assign oK2     = r_k2;
  assign oK3     = r_k3;
  assign oResult = r_result;

endmodule
`default_nettype wire

// File: doc/tea_stream_ctrl.md
# tea_stream_ctrl

Streaming front-end for the TEA cipher/decipher core. It collects key and plaintext words from a valid/ready input stream and presents them as stable operands on the core's data/key ports. It launches the core with a one-cycle start pulse, waits for `oDone` under a watchdog, and returns the 2-word result on a valid/ready output stream. It sits directly upstream and downstream of the core: it drives `iV0/iV1/iK0..iK3` and the core's start input, and consumes `oC0/oC1/oDone`.

## Interface
- `WORD_SIZE`, 16: width of every data/key word.
- `TIMEOUT`, 256: maximum WAIT cycles allowed before the frame is aborted.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `iData` in WORD_SIZE: input stream word.
- `iValid` in 1: input word valid.
- `oReady` out 1: ready to accept an input word.
- `iNewKey` in 1: frame carries a new key; exists only with TEA_KEY_RETAIN_EN.
- `oV0`, `oV1` out WORD_SIZE: data operands to the core.
- `oK0`..`oK3` out WORD_SIZE: key operands to the core.
- `oStart` out 1: one-cycle start pulse, wired to the core's `rst`.
- `iC0`, `iC1` in WORD_SIZE: core results.
- `iDone` in 1: core done.
- `oResult` out 2*WORD_SIZE: result word, {C0,C1}.
- `oValid` out 1: result valid.
- `iReady` in 1: downstream ready.
- `oBusy` out 1: high in START, WAIT and OUT.
- `oTimeout` out 1: one-cycle pulse when a frame is aborted.

## Operation
- FSM states: LOAD, START, WAIT, OUT.
- LOAD
  - `oReady`=1; a word is accepted when `iValid && oReady`.
  - A 3-bit word counter steers each accepted word, in order, to K0, K1, K2, K3, V0, V1.
  - Acceptance of the last word clears the counter and moves the FSM to START.
- START: `oStart`=1 for exactly one cycle, then go to WAIT.
- WAIT
  - `iDone` is ignored in the first WAIT cycle, because done may be stale before the core reset takes effect.
  - From the second WAIT cycle, `iDone`=1 captures `{iC0,iC1}` into `oResult` and moves the FSM to OUT.
  - The watchdog counts WAIT cycles. On reaching TIMEOUT with no done: pulse `oTimeout`, discard the frame, return to LOAD. `oValid` is not raised.
- OUT
  - `oValid`=1; `oResult` is held stable until `iReady`.
  - On the handshake: `oValid`→0, go to LOAD.
- `oV*`/`oK*` hold their values from capture until overwritten by the next frame; they are never cleared between frames.
- Input words arriving outside LOAD are not accepted (`oReady`=0).
- Reset values: `oReady`=1 after reset, since reset state is LOAD. All of the following are 0: `oStart`, `oValid`, `oBusy`, `oTimeout`, `oResult`, `oV0`, `oV1`, `oK0`..`oK3`, word counter, watchdog.
- Reset mid-operation, in any state: immediate return to LOAD with everything cleared. A partially loaded frame is lost. A pending `oValid` drops asynchronously.

## Timing
- Last input word accepted at edge n:
  - `oStart`=1 during cycle n+1.
  - WAIT entered at n+2.
  - `iDone` honoured from n+3.
- `iDone` seen at edge m: `oValid`=1 and `oResult` valid from cycle m+1.
- OUT handshake at edge k: `oReady`=1 from cycle k+1. Back-to-back frames therefore lose no cycles beyond the handshake.
- Minimum frame turnaround is 6 load cycles + 1 start + core latency + 1 out.
- Timeout fires on the TIMEOUT-th WAIT cycle without done. `oTimeout` is high for that one cycle and the FSM is in LOAD on the next cycle.

## Configuration
- `TEA_KEY_RETAIN_EN` defined:
  - The `iNewKey` port exists and is sampled with the first word of each frame.
  - `iNewKey`=1: 6-word frame, same as without the macro.
  - `iNewKey`=0: 2-word frame (V0, V1) that reuses the retained K0..K3.
  - A 2-word frame directly after reset uses all-zero keys.
- Not defined: no `iNewKey` port; every frame is 6 words.

## Structure
- Shared package `tea_pkg`: FSM state encoding, frame-length constants (6, 2), default WORD_SIZE, and word-index constants (K0=0 … V1=5).
- One sub-module, `tea_watchdog`: a loadable WAIT-cycle counter with a clear input and a `expired` output. Its width is sized for TIMEOUT.

## Test plan
- Six words cf42, cb45, acbe, f235, 5986, 6d67 with `iValid` held high:
  - `oK0..oK3`=cf42/cb45/acbe/f235 and `oV0/oV1`=5986/6d67.
  - `oStart` high for one cycle, exactly 1 cycle after the 6th accept.
- Core model asserts done 33 cycles after start with C0=a5a5, C1=5a5a:
  - `oResult`=a5a55a5a and `oValid` high the next cycle.
  - With `iReady` held 0 for 5 cycles, the result stays stable; it clears on the handshake.
- Stale `iDone`=1 held through START and the first WAIT cycle, then low: no capture occurs, and capture happens only on a later done.
- Core model never asserts done (TIMEOUT=16): one `oTimeout` pulse after 16 WAIT cycles, `oValid` never rises, and `oReady`=1 on the next cycle.
- Reset asserted after 3 of 6 words and again during OUT: all outputs return to reset values immediately, and the next full frame completes normally.
- With TEA_KEY_RETAIN_EN: a 6-word frame (`iNewKey`=1), then a 2-word frame 1111, 2222 (`iNewKey`=0):
  - Keys are unchanged, `oV0/oV1`=1111/2222.
  - Start fires 1 cycle after the 2nd word.
